rv64i_core: RTL and testbench

Multicycle RV64I integer core with an integrated unified instruction/data memory and a 32×64 register file. It is the top of the FPGA build and has no bus interface. Software and register state are preloaded by backdoor writes into the memory and register-file arrays, then the core runs from PC 0 until it halts.

---
 rtl/rv64i_pkg.sv | 56 +++++
 rtl/rv64i_regfile.sv | 22 ++
 rtl/rv64i_core.sv | 239 +++++++++++++++++++++++
 tb/tb_rv64i_core.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv64i_pkg.sv
// Shared definitions for the rv64i core: opcode and funct constants, FSM and ALU enums,
// and the integer ALU datapath shared by 64-bit and W-suffixed operations.
package rv64i_pkg;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    localparam logic [2:0] F3_ADD  = 3'd0, F3_SLL = 3'd1, F3_SLT = 3'd2, F3_SLTU = 3'd3;
    localparam logic [2:0] F3_XOR  = 3'd4, F3_SR  = 3'd5, F3_OR  = 3'd6, F3_AND  = 3'd7;
    localparam logic [2:0] F3_BEQ  = 3'd0, F3_BNE = 3'd1, F3_BLT = 3'd4, F3_BGE  = 3'd5;
    localparam logic [2:0] F3_BLTU = 3'd6, F3_BGEU = 3'd7;
    localparam logic [2:0] F3_B    = 3'd0, F3_H   = 3'd1, F3_W   = 3'd2, F3_D    = 3'd3;
    localparam logic [2:0] F3_BU   = 3'd4, F3_HU  = 3'd5, F3_WU  = 3'd6;
    localparam logic [6:0] F7_BASE = 7'b0000000, F7_ALT = 7'b0100000;

    localparam logic [31:0] INSN_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {ST_FETCH, ST_EXEC, ST_MEM_LO, ST_MEM_HI} state_t;
    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_t;

    // W ops shift by 5 bits and sign-extend the low 32 bits of the result.
    function automatic logic [63:0] alu_calc(input alu_op_t op, input logic [63:0] a,
                                             input logic [63:0] b, input logic word);
        logic [63:0] r;
        logic [5:0]  sh;
        sh = word ? {1'b0, b[4:0]} : b[5:0];
        case (op)
            ALU_ADD:  r = a + b;
            ALU_SUB:  r = a - b;
            ALU_SLL:  r = a << sh;
            ALU_SLT:  r = {63'd0, $signed(a) < $signed(b)};
            ALU_SLTU: r = {63'd0, a < b};
            ALU_XOR:  r = a ^ b;
            ALU_SRL:  r = (word ? {32'd0, a[31:0]} : a) >> sh;
            ALU_SRA:  r = $unsigned($signed(word ? {{32{a[31]}}, a[31:0]} : a) >>> sh);
            ALU_OR:   r = a | b;
            ALU_AND:  r = a & b;
            default:  r = '0;
        endcase
        if (word) r = {{32{r[31]}}, r[31:0]};
        return r;
    endfunction
endpackage

// File: rtl/rv64i_regfile.sv
// 32 x XLEN register file: two asynchronous read ports, one synchronous write port, x0 reads zero.
module rv64i_regfile #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    input  logic            we,
    input  logic [4:0]      rd_addr,
    input  logic [XLEN-1:0] rd_data
);
    logic [XLEN-1:0] rf [0:31];

    assign rs1_data = (rs1_addr == 5'd0) ? '0 : rf[rs1_addr];
    assign rs2_data = (rs2_addr == 5'd0) ? '0 : rf[rs2_addr];

    always_ff @(posedge clk) begin
        if (we && rd_addr != 5'd0) rf[rd_addr] <= rd_data;
    end
endmodule

// File: rtl/rv64i_core.sv
// Multicycle RV64I core (FETCH/EXEC/MEM_LO/MEM_HI) with unified 32-bit-word memory.
// Decode, immediates, ALU control and load/store lane alignment live in the top.
module rv64i_main_mem #(
    parameter int DEPTH = 4096
) (
    input  logic                     clk,
    input  logic [$clog2(DEPTH)-1:0] idx,
    output logic [31:0]              rdata,
    input  logic                     we,
    input  logic [3:0]               be,
    input  logic [31:0]              wdata
);
    logic [31:0] MEM [0:DEPTH-1];

    assign rdata = MEM[idx];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++)
                if (be[i]) MEM[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
    end
endmodule

module rv64i_core
    import rv64i_pkg::*;
#(
    parameter int XLEN      = 64,
    parameter int MEM_DEPTH = 4096
) (
    input  logic            i_riscv_core_clk,
    input  logic            i_riscv_core_rst,
    output logic [XLEN-1:0] o_riscv_core_pc,
    output logic            o_riscv_core_halt
);
    localparam int AW = $clog2(MEM_DEPTH);

    logic            clk, rst;
    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d, addr_q, addr_d;
    logic [31:0]     ir_q, lo_q, lo_d, mem_rdata, mem_wdata, shifted;
    logic            halt_q, halt_d, rf_we, mem_we, illegal, taken, is_word;
    logic [3:0]      mem_be;
    logic [XLEN-1:0] mem_byte_addr, rs1, rs2, rf_wdata, alu_b, alu_res, ea, load_val;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [6:0]      opcode, f7;
    logic [2:0]      f3;
    logic [4:0]      rd;
    alu_op_t         alu_op;
    logic            unused_addr_bits;

    assign clk = i_riscv_core_clk;
    assign rst = i_riscv_core_rst;
    assign o_riscv_core_pc   = pc_q;
    assign o_riscv_core_halt = halt_q;

    assign opcode = ir_q[6:0];
    assign rd     = ir_q[11:7];
    assign f3     = ir_q[14:12];
    assign f7     = ir_q[31:25];
    assign imm_i  = {{52{ir_q[31]}}, ir_q[31:20]};
    assign imm_s  = {{52{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
    assign imm_b  = {{51{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
    assign imm_u  = {{32{ir_q[31]}}, ir_q[31:12], 12'd0};
    assign imm_j  = {{43{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};

    rv64i_regfile #(.XLEN(XLEN)) u_rf (
        .clk(clk), .rs1_addr(ir_q[19:15]), .rs2_addr(ir_q[24:20]),
        .rs1_data(rs1), .rs2_data(rs2),
        .we(rf_we && !rst), .rd_addr(rd), .rd_data(rf_wdata)
    );

    rv64i_main_mem #(.DEPTH(MEM_DEPTH)) u_main_mem (
        .clk(clk), .idx(mem_byte_addr[AW+1:2]), .rdata(mem_rdata),
        .we(mem_we && !rst), .be(mem_be), .wdata(mem_wdata)
    );

    assign unused_addr_bits = ^{mem_byte_addr[XLEN-1:AW+2], mem_byte_addr[1:0]};

    always_comb begin
        alu_op = ALU_ADD;
        case (f3)
            F3_ADD:  alu_op = ((opcode == OPC_OP || opcode == OPC_OP_32) && f7[5]) ? ALU_SUB : ALU_ADD;
            F3_SLL:  alu_op = ALU_SLL;
            F3_SLT:  alu_op = ALU_SLT;
            F3_SLTU: alu_op = ALU_SLTU;
            F3_XOR:  alu_op = ALU_XOR;
            F3_SR:   alu_op = f7[5] ? ALU_SRA : ALU_SRL;
            F3_OR:   alu_op = ALU_OR;
            F3_AND:  alu_op = ALU_AND;
            default: alu_op = ALU_ADD;
        endcase
    end

    assign is_word = (opcode == OPC_OP_32) || (opcode == OPC_OP_IMM_32);
    assign alu_b   = (opcode == OPC_OP || opcode == OPC_OP_32) ? rs2 : imm_i;
    assign alu_res = alu_calc(alu_op, rs1, alu_b, is_word);

    always_comb begin
        case (f3)
            F3_BEQ:  taken = (rs1 == rs2);
            F3_BNE:  taken = (rs1 != rs2);
            F3_BLT:  taken = ($signed(rs1) < $signed(rs2));
            F3_BGE:  taken = ($signed(rs1) >= $signed(rs2));
            F3_BLTU: taken = (rs1 < rs2);
            F3_BGEU: taken = (rs1 >= rs2);
            default: taken = 1'b0;
        endcase
    end

    // Every SYSTEM encoding halts: ECALL/EBREAK by definition, the rest as illegal.
    always_comb begin
        case (opcode)
            OPC_LOAD:      illegal = (f3 == 3'd7);
            OPC_STORE:     illegal = f3[2];
            OPC_BRANCH:    illegal = (f3 == 3'd2) || (f3 == 3'd3);
            OPC_JALR:      illegal = (f3 != 3'd0);
            OPC_OP:        illegal = (f7 != F7_BASE) && !(f7 == F7_ALT && (f3 == F3_ADD || f3 == F3_SR));
            OPC_OP_32:     illegal = !(f3 == F3_ADD || f3 == F3_SLL || f3 == F3_SR) ||
                                     ((f7 != F7_BASE) && !(f7 == F7_ALT && (f3 == F3_ADD || f3 == F3_SR)));
            OPC_OP_IMM_32: illegal = !(f3 == F3_ADD || f3 == F3_SLL || f3 == F3_SR);
            OPC_OP_IMM, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_MISC_MEM: illegal = 1'b0;
            default:       illegal = 1'b1;
        endcase
    end

    always_comb begin
        ea = rs1 + ((opcode == OPC_STORE) ? imm_s : imm_i);
        case (f3[1:0])
            2'd1:    ea[0]   = 1'b0;
            2'd2:    ea[1:0] = 2'b00;
            2'd3:    ea[2:0] = 3'b000;
            default: ;
        endcase
    end

    always_comb begin
        shifted = mem_rdata >> {addr_q[1:0], 3'b000};
        case (f3)
            F3_B:    load_val = {{56{shifted[7]}}, shifted[7:0]};
            F3_H:    load_val = {{48{shifted[15]}}, shifted[15:0]};
            F3_W:    load_val = {{32{shifted[31]}}, shifted};
            F3_BU:   load_val = {56'd0, shifted[7:0]};
            F3_HU:   load_val = {48'd0, shifted[15:0]};
            default: load_val = {32'd0, shifted};
        endcase
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        halt_d        = halt_q;
        addr_d        = addr_q;
        lo_d          = lo_q;
        rf_we         = 1'b0;
        rf_wdata      = alu_res;
        mem_we        = 1'b0;
        mem_be        = 4'b0000;
        mem_wdata     = rs2[31:0];
        mem_byte_addr = pc_q;
        case (state_q)
            ST_FETCH: if (!halt_q) state_d = ST_EXEC;
            ST_EXEC: begin
                state_d = ST_FETCH;
                pc_d    = pc_q + 64'd4;
                if (illegal) begin
                    halt_d = 1'b1;
                    pc_d   = pc_q;
                end else begin
                    case (opcode)
                        OPC_LUI:   begin rf_we = 1'b1; rf_wdata = imm_u; end
                        OPC_AUIPC: begin rf_we = 1'b1; rf_wdata = pc_q + imm_u; end
                        OPC_JAL:   begin rf_we = 1'b1; rf_wdata = pc_q + 64'd4; pc_d = pc_q + imm_j; end
                        OPC_JALR:  begin rf_we = 1'b1; rf_wdata = pc_q + 64'd4;
                                         pc_d = (rs1 + imm_i) & ~64'd1; end
                        OPC_BRANCH: if (taken) pc_d = pc_q + imm_b;
                        OPC_OP, OPC_OP_IMM, OPC_OP_32, OPC_OP_IMM_32: rf_we = 1'b1;
                        OPC_LOAD, OPC_STORE: begin
                            addr_d  = ea;
                            pc_d    = pc_q;
                            state_d = ST_MEM_LO;
                        end
                        default: ;
                    endcase
                end
            end
            ST_MEM_LO: begin
                mem_byte_addr = addr_q;
                lo_d          = mem_rdata;
                if (opcode == OPC_STORE) begin
                    mem_we = 1'b1;
                    case (f3[1:0])
                        2'd0:    begin mem_be = 4'b0001 << addr_q[1:0]; mem_wdata = {4{rs2[7:0]}}; end
                        2'd1:    begin mem_be = 4'b0011 << addr_q[1:0]; mem_wdata = {2{rs2[15:0]}}; end
                        default: mem_be = 4'b1111;
                    endcase
                end else begin
                    rf_wdata = load_val;
                end
                if (f3[1:0] == 2'd3) begin
                    state_d = ST_MEM_HI;
                end else begin
                    rf_we   = (opcode == OPC_LOAD);
                    pc_d    = pc_q + 64'd4;
                    state_d = ST_FETCH;
                end
            end
            ST_MEM_HI: begin
                mem_byte_addr = addr_q + 64'd4;
                rf_we         = (opcode == OPC_LOAD);
                rf_wdata      = {mem_rdata, lo_q};
                mem_we        = (opcode == OPC_STORE);
                mem_be        = 4'b1111;
                mem_wdata     = rs2[63:32];
                pc_d          = pc_q + 64'd4;
                state_d       = ST_FETCH;
            end
            default: state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FETCH;
            pc_q    <= '0;
            halt_q  <= 1'b0;
            ir_q    <= INSN_NOP;
            addr_q  <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            halt_q  <= halt_d;
            addr_q  <= addr_d;
            lo_q    <= lo_d;
            if (state_q == ST_FETCH && !halt_q) ir_q <= mem_rdata;
        end
    end
endmodule

// File: tb/tb_rv64i_core.sv
// Directed bench for rv64i_core: backdoor-loaded programs, hand-computed register,
// memory, PC and halt expectations, including a reset in the middle of an SD.
module tb_rv64i_core;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] pc;
    logic        halt;
    int          total = 0;
    int          bad = 0;
    int unsigned pp;

    localparam logic [31:0] ECALL  = 32'h0000_0073;
    localparam logic [31:0] EBREAK = 32'h0010_0073;

    rv64i_core #(.XLEN(64), .MEM_DEPTH(4096)) dut (
        .i_riscv_core_clk(clk),
        .i_riscv_core_rst(rst),
        .o_riscv_core_pc(pc),
        .o_riscv_core_halt(halt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] r_t(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {f7, rs2, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] i_t(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] s_t(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] b_t(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
    endfunction
    function automatic logic [31:0] j_t(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Holds reset, clears registers and the low memory (zero words are illegal, so a stray PC halts).
    task automatic start_test();
        rst = 1'b1;
        tick(2);
        for (int i = 0; i < 32; i++) dut.u_rf.rf[i] = '0;
        for (int i = 0; i < 256; i++) dut.u_main_mem.MEM[i] = 32'h0;
        pp = 0;
    endtask

    task automatic emit(input logic [31:0] w);
        dut.u_main_mem.MEM[pp] = w;
        pp++;
    endtask

    task automatic setr(input int n, input logic [63:0] v);
        dut.u_rf.rf[n] = v;
    endtask

    task automatic run_to_halt(input string tag, input int budget);
        int n = 0;
        while (!halt && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {63'd0, halt}, 64'd1);
    endtask

    initial begin
        // ALU: 2 cycles per instruction
        start_test();
        setr(1, 64'd5);
        setr(2, 64'hFFFF_FFFF_FFFF_FFFD);
        emit(r_t(7'h00, 2, 1, 3'd0, 3, 7'h33));
        emit(r_t(7'h20, 2, 1, 3'd0, 6, 7'h33));
        emit(r_t(7'h00, 2, 1, 3'd2, 7, 7'h33));
        emit(r_t(7'h00, 2, 1, 3'd3, 8, 7'h33));
        emit(r_t(7'h20, 1, 2, 3'd5, 4, 7'h33));
        emit(ECALL);
        chk("rst_pc", pc, 64'd0);
        chk("rst_halt", {63'd0, halt}, 64'd0);
        rst = 1'b0;
        tick(2);
        chk("alu_pc_2cyc", pc, 64'h4);
        tick(8);
        chk("alu_pc_10cyc", pc, 64'h14);
        tick(2);
        chk("alu_halt", {63'd0, halt}, 64'd1);
        chk("alu_halt_pc", pc, 64'h14);
        chk("add", dut.u_rf.rf[3], 64'd2);
        chk("sub", dut.u_rf.rf[6], 64'd8);
        chk("slt", dut.u_rf.rf[7], 64'd0);
        chk("sltu", dut.u_rf.rf[8], 64'd1);
        chk("sra", dut.u_rf.rf[4], 64'hFFFF_FFFF_FFFF_FFFF);

        // W-ops and 64-bit shift amounts
        start_test();
        setr(1, 64'h0000_0000_7FFF_FFFF);
        setr(5, 64'd1);
        emit(i_t(12'h001, 1, 3'd0, 2, 7'h1B));
        emit(i_t(12'h01F, 5, 3'd1, 3, 7'h1B));
        emit(i_t(12'h404, 3, 3'd5, 4, 7'h1B));
        emit(i_t(12'h004, 3, 3'd5, 6, 7'h1B));
        emit(r_t(7'h00, 1, 1, 3'd0, 7, 7'h3B));
        emit(i_t(12'h028, 5, 3'd1, 8, 7'h13));
        emit(r_t(7'h20, 1, 5, 3'd0, 9, 7'h3B));
        emit(i_t(12'h024, 3, 3'd5, 10, 7'h13));
        emit(ECALL);
        rst = 1'b0;
        run_to_halt("w_halt", 100);
        chk("addiw", dut.u_rf.rf[2], 64'hFFFF_FFFF_8000_0000);
        chk("slliw", dut.u_rf.rf[3], 64'hFFFF_FFFF_8000_0000);
        chk("sraiw", dut.u_rf.rf[4], 64'hFFFF_FFFF_F800_0000);
        chk("srliw", dut.u_rf.rf[6], 64'h0000_0000_0800_0000);
        chk("addw", dut.u_rf.rf[7], 64'hFFFF_FFFF_FFFF_FFFE);
        chk("slli40", dut.u_rf.rf[8], 64'h0000_0100_0000_0000);
        chk("subw", dut.u_rf.rf[9], 64'hFFFF_FFFF_8000_0002);
        chk("srli36", dut.u_rf.rf[10], 64'h0000_0000_0FFF_FFFF);

        // Memory round-trip, lane selection and forced alignment
        start_test();
        setr(3, 64'h100);
        setr(5, 64'h1122_3344_5566_7788);
        emit(s_t(12'd0, 5, 3, 3'd3));
        emit(i_t(12'd0, 3, 3'd3, 6, 7'h03));
        emit(i_t(12'd0, 3, 3'd2, 7, 7'h03));
        emit(i_t(12'd4, 3, 3'd2, 8, 7'h03));
        emit(i_t(12'd0, 3, 3'd6, 9, 7'h03));
        emit(i_t(12'd7, 3, 3'd0, 10, 7'h03));
        emit(i_t(12'd0, 3, 3'd0, 11, 7'h03));
        emit(i_t(12'd0, 3, 3'd4, 12, 7'h03));
        emit(i_t(12'd6, 3, 3'd1, 13, 7'h03));
        emit(i_t(12'd1, 3, 3'd1, 15, 7'h03));
        emit(i_t(12'd3, 3, 3'd3, 16, 7'h03));
        emit(s_t(12'd9, 5, 3, 3'd0));
        emit(i_t(12'd9, 3, 3'd4, 17, 7'h03));
        emit(i_t(12'd9, 3, 3'd0, 18, 7'h03));
        emit(s_t(12'd14, 5, 3, 3'd1));
        emit(ECALL);
        rst = 1'b0;
        tick(4);
        chk("sd_4cyc_pc", pc, 64'h4);
        chk("sd_mem_lo", {32'd0, dut.u_main_mem.MEM[64]}, 64'h5566_7788);
        chk("sd_mem_hi", {32'd0, dut.u_main_mem.MEM[65]}, 64'h1122_3344);
        tick(4);
        chk("ld_4cyc_pc", pc, 64'h8);
        tick(3);
        chk("lw_3cyc_pc", pc, 64'hC);
        run_to_halt("mem_halt", 200);
        chk("mem_halt_pc", pc, 64'h3C);
        chk("ld", dut.u_rf.rf[6], 64'h1122_3344_5566_7788);
        chk("lw0", dut.u_rf.rf[7], 64'h0000_0000_5566_7788);
        chk("lw4", dut.u_rf.rf[8], 64'h0000_0000_1122_3344);
        chk("lwu0", dut.u_rf.rf[9], 64'h0000_0000_5566_7788);
        chk("lb7", dut.u_rf.rf[10], 64'h11);
        chk("lb0", dut.u_rf.rf[11], 64'hFFFF_FFFF_FFFF_FF88);
        chk("lbu0", dut.u_rf.rf[12], 64'h88);
        chk("lh6", dut.u_rf.rf[13], 64'h1122);
        chk("lh_misalign", dut.u_rf.rf[15], 64'h7788);
        chk("ld_misalign", dut.u_rf.rf[16], 64'h1122_3344_5566_7788);
        chk("sb_mem", {32'd0, dut.u_main_mem.MEM[66]}, 64'h0000_8800);
        chk("lbu9", dut.u_rf.rf[17], 64'h88);
        chk("lb9", dut.u_rf.rf[18], 64'hFFFF_FFFF_FFFF_FF88);
        chk("sh_mem", {32'd0, dut.u_main_mem.MEM[67]}, 64'h7788_0000);

        // Control flow, x0 write drop, ECALL at 0x20
        start_test();
        setr(2, 64'd7);
        setr(3, 64'd7);
        setr(4, 64'h1C);
        emit(i_t(12'd5, 0, 3'd0, 0, 7'h13));
        emit(b_t(13'd8, 3, 2, 3'd0));
        emit(i_t(12'd1, 0, 3'd0, 5, 7'h13));
        emit(b_t(13'd8, 3, 2, 3'd1));
        emit(j_t(21'd8, 1));
        emit(i_t(12'd2, 0, 3'd0, 5, 7'h13));
        emit(i_t(12'd1, 4, 3'd0, 7, 7'h67));
        emit(i_t(12'd9, 0, 3'd0, 8, 7'h13));
        emit(ECALL);
        rst = 1'b0;
        tick(4);
        chk("beq_taken_pc", pc, 64'hC);
        tick(2);
        chk("bne_not_taken_pc", pc, 64'h10);
        tick(2);
        chk("jal_pc", pc, 64'h18);
        chk("jal_link", dut.u_rf.rf[1], 64'h14);
        tick(2);
        chk("jalr_pc_bit0", pc, 64'h1C);
        chk("jalr_link", dut.u_rf.rf[7], 64'h1C);
        tick(4);
        chk("ecall_halt", {63'd0, halt}, 64'd1);
        tick(6);
        chk("ecall_pc_frozen", pc, 64'h20);
        chk("x0_zero", dut.u_rf.rf[0], 64'd0);
        chk("x0_reads_zero", dut.u_rf.rf[8], 64'd9);
        chk("skipped_insns", dut.u_rf.rf[5], 64'd0);

        // LUI / AUIPC, ending on EBREAK
        start_test();
        emit({20'h80000, 5'd1, 7'h37});
        emit(32'h0000_0013);
        emit({20'h00001, 5'd2, 7'h17});
        emit(EBREAK);
        rst = 1'b0;
        run_to_halt("ebreak_halt", 50);
        chk("ebreak_pc", pc, 64'hC);
        chk("lui", dut.u_rf.rf[1], 64'hFFFF_FFFF_8000_0000);
        chk("auipc", dut.u_rf.rf[2], 64'h1008);

        // Illegal opcode halts with PC on the offending word
        start_test();
        emit(i_t(12'd3, 0, 3'd0, 1, 7'h13));
        emit(32'h0000_0000);
        rst = 1'b0;
        run_to_halt("illegal_halt", 50);
        chk("illegal_pc", pc, 64'h4);
        chk("illegal_prior_wr", dut.u_rf.rf[1], 64'd3);

        // Reset during MEM_LO of an SD: no write, state back to PC 0
        start_test();
        chk("rst_clears_halt", {63'd0, halt}, 64'd0);
        setr(3, 64'h200);
        setr(5, 64'hAAAA_AAAA_BBBB_BBBB);
        dut.u_main_mem.MEM[128] = 32'hDEAD_BEEF;
        dut.u_main_mem.MEM[129] = 32'hCAFE_F00D;
        emit(s_t(12'd0, 5, 3, 3'd3));
        emit(ECALL);
        rst = 1'b0;
        tick(2);
        rst = 1'b1;
        tick(1);
        chk("midrst_pc", pc, 64'd0);
        chk("midrst_halt", {63'd0, halt}, 64'd0);
        chk("midrst_mem_lo", {32'd0, dut.u_main_mem.MEM[128]}, 64'hDEAD_BEEF);
        chk("midrst_mem_hi", {32'd0, dut.u_main_mem.MEM[129]}, 64'hCAFE_F00D);
        rst = 1'b0;
        run_to_halt("rerun_halt", 50);
        chk("rerun_pc", pc, 64'h4);
        chk("rerun_mem_lo", {32'd0, dut.u_main_mem.MEM[128]}, 64'hBBBB_BBBB);
        chk("rerun_mem_hi", {32'd0, dut.u_main_mem.MEM[129]}, 64'hAAAA_AAAA);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
